// File: rtl/terminal_port_arbiter_if.sv
// terminal_port_arbiter_if: requester A/B, clear control and terminal text port.
// slave = arbiter view, master = requesters + terminal view.
//   a_*/b_*  : req/write/addr/wdata in, gnt/rvalid/rdata out (slave view)
//   clear_*  : clear_start in, clear_busy out
//   text_*   : addr/write/wdata out, rdata in
interface terminal_port_arbiter_if;
    logic        a_req;
    logic        a_write;
    logic [11:0] a_addr;
    logic [7:0]  a_wdata;
    logic        a_gnt;
    logic        a_rvalid;
    logic [7:0]  a_rdata;

    logic        b_req;
    logic        b_write;
    logic [11:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic [7:0]  b_rdata;

    logic        clear_start;
    logic        clear_busy;

    logic [11:0] text_addr;
    logic        text_write;
    logic [7:0]  text_wdata;
    logic [7:0]  text_rdata;

    modport slave (
        input  a_req, a_write, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_write, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        input  clear_start,
        output clear_busy,
        output text_addr, text_write, text_wdata,
        input  text_rdata
    );

    modport master (
        output a_req, a_write, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_write, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        output clear_start,
        input  clear_busy,
        input  text_addr, text_write, text_wdata,
        output text_rdata
    );
endinterface

// File: rtl/terminal_port_arbiter.sv
// terminal_port_arbiter: shares the terminal text port between debugger (A)
// and CPU console (B) with round-robin arbitration, plus a buffer clear sweep.
// Ports: clock, reset (async active-low), bus (terminal_port_arbiter_if.slave).
//   Grants are combinational; all terminal-side outputs are registered.
//   Reads return x_rvalid/x_rdata two cycles after the grant.
// Option: define TERM_ARB_FIXED_PRIORITY_EN to make A always win ties.
module terminal_port_arbiter #(
    parameter int unsigned TEXT_DEPTH = 2400,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input logic                     clock,
    input logic                     reset,
    terminal_port_arbiter_if.slave  bus
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [11:0] LAST_CELL = 12'(TEXT_DEPTH - 1);

    state_t      state;
    state_t      state_nxt;
    logic [11:0] clr_cnt;
    logic [11:0] clr_cnt_nxt;

    logic        tie;
    logic        gnt_a;
    logic        gnt_b;
    logic        rd_issue;

    // Stage 1 of the read pipeline: a read was presented on text_addr
    // this cycle; rd_tag says who owns it (0 = A, 1 = B).
    logic        rd_pend;
    logic        rd_tag;

    logic [11:0] text_addr_q;
    logic        text_write_q;
    logic [7:0]  text_wdata_q;
    logic        a_rvalid_q;
    logic        b_rvalid_q;
    logic [7:0]  a_rdata_q;
    logic [7:0]  b_rdata_q;

`ifndef TERM_ARB_FIXED_PRIORITY_EN
    // Last tie winner: 1 = B, 0 = A. Reset to B so A wins the first tie.
    logic        rr_last;
`endif

    // Grant selection
    always_comb begin
        tie   = bus.a_req && bus.b_req;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (state == ARB) begin
            if (tie) begin
`ifdef TERM_ARB_FIXED_PRIORITY_EN
                gnt_a = 1'b1;
`else
                gnt_a = rr_last;
                gnt_b = !rr_last;
`endif
            end else begin
                gnt_a = bus.a_req;
                gnt_b = bus.b_req;
            end
        end
    end

    assign rd_issue = (gnt_a && !bus.a_write) ||
                      (gnt_b && !bus.b_write);

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        unique case (state)
            ARB: begin
                if (bus.clear_start) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = 12'd0;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST_CELL) begin
                    state_nxt = ARB;
                end else begin
                    clr_cnt_nxt = clr_cnt + 12'd1;
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ARB;
            clr_cnt <= 12'd0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

`ifndef TERM_ARB_FIXED_PRIORITY_EN
    // Only a contested cycle moves the round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_last <= 1'b1;
        end else if (tie && (state == ARB)) begin
            rr_last <= gnt_b;
        end
    end
`endif

    // Terminal-side registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            text_addr_q  <= 12'd0;
            text_write_q <= 1'b0;
            text_wdata_q <= 8'd0;
        end else begin
            unique case (1'b1)
                (state == CLEAR): begin
                    text_addr_q  <= clr_cnt;
                    text_write_q <= 1'b1;
                    text_wdata_q <= CLEAR_CHAR;
                end
                gnt_a: begin
                    text_addr_q  <= bus.a_addr;
                    text_write_q <= bus.a_write;
                    text_wdata_q <= bus.a_wdata;
                end
                gnt_b: begin
                    text_addr_q  <= bus.b_addr;
                    text_write_q <= bus.b_write;
                    text_wdata_q <= bus.b_wdata;
                end
                default: begin
                    text_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Read return pipeline: text_rdata belongs to the address presented
    // in the same cycle, so it is captured one edge after the grant edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_pend    <= 1'b0;
            rd_tag     <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= 8'd0;
            b_rdata_q  <= 8'd0;
        end else begin
            rd_pend    <= rd_issue;
            rd_tag     <= gnt_b;
            a_rvalid_q <= rd_pend && !rd_tag;
            b_rvalid_q <= rd_pend && rd_tag;
            if (rd_pend && !rd_tag) begin
                a_rdata_q <= bus.text_rdata;
            end
            if (rd_pend && rd_tag) begin
                b_rdata_q <= bus.text_rdata;
            end
        end
    end

    assign bus.a_gnt      = gnt_a;
    assign bus.b_gnt      = gnt_b;
    assign bus.a_rvalid   = a_rvalid_q;
    assign bus.b_rvalid   = b_rvalid_q;
    assign bus.a_rdata    = a_rdata_q;
    assign bus.b_rdata    = b_rdata_q;
    assign bus.clear_busy = (state == CLEAR);
    assign bus.text_addr  = text_addr_q;
    assign bus.text_write = text_write_q;
    assign bus.text_wdata = text_wdata_q;

endmodule
